cacheline_arbiter: RTL

//   Shares the single cacheline-wide memory port between the I-cache (read-only) and the
//   D-side path (D-cache through the eviction buffer; read and write). One transaction is

---
 rtl/cacheline_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline-wide memory port between the I-cache and the D-side path.
// One transaction at a time; the winning request is latched and ties alternate round-robin.
module cacheline_arbiter #(
    parameter int cacheline_size = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      icache_read,
    input  logic [31:0]               icache_address,
    output logic [cacheline_size-1:0] icache_rdata,
    output logic                      icache_resp,
    input  logic                      dcache_read,
    input  logic                      dcache_write,
    input  logic [31:0]               dcache_address,
    input  logic [cacheline_size-1:0] dcache_wdata,
    output logic [cacheline_size-1:0] dcache_rdata,
    output logic                      dcache_resp,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [31:0]               mem_address,
    output logic [cacheline_size-1:0] mem_wdata,
    input  logic [cacheline_size-1:0] mem_rdata,
    input  logic                      mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
    localparam logic GRANT_I  = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    state_t                    state;
    logic [31:0]               addr_q;
    logic [cacheline_size-1:0] wdata_q;
    logic                      op_q;
    logic                      last_grant;

    logic i_pend;
    logic d_pend;
    logic grant_d;
    logic grant_i;
    logic busy;

    assign i_pend = icache_read;
    assign d_pend = dcache_read | dcache_write;

    // D wins when it is alone or when I was the most recent winner.
    assign grant_d = d_pend && (!i_pend || (last_grant == GRANT_I));
    assign grant_i = i_pend && !grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_READ;
            last_grant <= GRANT_I;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        addr_q     <= dcache_address;
                        wdata_q    <= dcache_wdata;
                        op_q       <= dcache_write ? OP_WRITE : OP_READ;
                        last_grant <= GRANT_D;
                        state      <= SERVE_D;
                    end else if (grant_i) begin
                        addr_q     <= icache_address;
                        op_q       <= OP_READ;
                        last_grant <= GRANT_I;
                        state      <= SERVE_I;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory side is a pure function of the latched transaction, so it cannot glitch with requester churn.
    assign busy        = (state != IDLE);
    assign mem_read    = busy && (op_q == OP_READ);
    assign mem_write   = busy && (op_q == OP_WRITE);
    assign mem_address = busy ? addr_q : '0;
    assign mem_wdata   = (busy && (op_q == OP_WRITE)) ? wdata_q : '0;

    assign icache_resp  = (state == SERVE_I) && mem_resp;
    assign dcache_resp  = (state == SERVE_D) && mem_resp;
    assign icache_rdata = icache_resp ? mem_rdata : '0;
    assign dcache_rdata = dcache_resp ? mem_rdata : '0;

endmodule
